// File: rtl/hwpe_stream_zero_fault_ctrl_if.sv
// Control/status bundle between the zero-network fault controller and its
// register-file front end.
interface hwpe_stream_zero_fault_ctrl_if #(
    parameter int unsigned NB_CHAN   = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned IDX_W     = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
);
    logic                         enable_i;
    logic                         clear_i;
    logic [NB_CHAN-1:0]           mask_i;
    logic [NB_CHAN-1:0]           fault_i;
    logic [NB_CHAN-1:0]           fault_status_o;
    logic [IDX_W-1:0]             first_idx_o;
    logic                         fault_irq_o;
    logic                         armed_o;
    logic [NB_CHAN*CNT_WIDTH-1:0] fault_cnt_o;

    modport slave (
        input  enable_i, clear_i, mask_i, fault_i,
        output fault_status_o, first_idx_o, fault_irq_o, armed_o, fault_cnt_o
    );

    modport master (
        output enable_i, clear_i, mask_i, fault_i,
        input  fault_status_o, first_idx_o, fault_irq_o, armed_o, fault_cnt_o
    );
endinterface

// File: rtl/hwpe_stream_zero_fault_ctrl.sv
// Fault collector for the HWPE-Stream zero network: arming mask, sticky status,
// first-fault index and level irq. Per-channel counters under HWPE_STREAM_ZERO_FAULT_CNT_EN.
module hwpe_stream_zero_fault_ctrl #(
    parameter int unsigned NB_CHAN    = 4,
    parameter int unsigned ARM_CYCLES = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic                         clk_i,
    input logic                         rst_ni,
    hwpe_stream_zero_fault_ctrl_if.slave ctrl
);
    localparam int unsigned IDX_W    = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;
    localparam logic [7:0]  ARM_LOAD = (ARM_CYCLES > 0) ? 8'(ARM_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {DISABLED, ARMING, MONITOR, FAULT} state_e;

    state_e             state_q;
    logic [7:0]         arm_q;
    logic [NB_CHAN-1:0] status_q;
    logic [IDX_W-1:0]   first_q;
    logic               irq_q;
    logic               armed_q;

    logic [NB_CHAN-1:0] eff;
    logic               eval;
    logic [IDX_W-1:0]   low_idx;

    assign eff  = ctrl.fault_i & ~ctrl.mask_i;
    assign eval = ctrl.enable_i && (state_q == MONITOR || state_q == FAULT);

    always_comb begin
        low_idx = '0;
        for (int i = NB_CHAN - 1; i >= 0; i--)
            if (eff[i]) low_idx = IDX_W'(i);
    end

    // Later non-blocking writes override the clear defaults, so a fault that
    // collides with clear_i wins and lands on freshly zeroed status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= DISABLED;
            arm_q    <= '0;
            status_q <= '0;
            first_q  <= '0;
            irq_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            if (ctrl.clear_i) begin
                status_q <= '0;
                first_q  <= '0;
            end
            case (state_q)
                DISABLED: begin
                    if (ctrl.enable_i) begin
                        if (ARM_CYCLES == 0) begin
                            state_q <= MONITOR;
                            armed_q <= 1'b1;
                        end else begin
                            state_q <= ARMING;
                            arm_q   <= ARM_LOAD;
                        end
                    end
                end
                ARMING: begin
                    if (!ctrl.enable_i) begin
                        state_q <= DISABLED;
                    end else if (arm_q == 8'd0) begin
                        state_q <= MONITOR;
                        armed_q <= 1'b1;
                    end else begin
                        arm_q <= arm_q - 8'd1;
                    end
                end
                MONITOR, FAULT: begin
                    if (!ctrl.enable_i) begin
                        state_q <= DISABLED;
                        armed_q <= 1'b0;
                        irq_q   <= 1'b0;
                    end else if (|eff) begin
                        state_q  <= FAULT;
                        irq_q    <= 1'b1;
                        status_q <= (ctrl.clear_i ? '0 : status_q) | eff;
                        if (state_q == MONITOR || ctrl.clear_i) first_q <= low_idx;
                    end else if (ctrl.clear_i) begin
                        state_q <= MONITOR;
                        irq_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DISABLED;
                    armed_q <= 1'b0;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl.fault_status_o = status_q;
    assign ctrl.first_idx_o    = first_q;
    assign ctrl.fault_irq_o    = irq_q;
    assign ctrl.armed_o        = armed_q;

`ifdef HWPE_STREAM_ZERO_FAULT_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NB_CHAN-1:0][CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NB_CHAN; i++) begin
                if (eval && eff[i]) begin
                    if (ctrl.clear_i)           cnt_q[i] <= CNT_WIDTH'(1);
                    else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end else if (ctrl.clear_i) begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign ctrl.fault_cnt_o = cnt_q;
`else
    assign ctrl.fault_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_zero_fault_ctrl.sv
// Directed bench for the zero-network fault controller (NB_CHAN=4, ARM_CYCLES=4, CNT_WIDTH=3).
module tb_hwpe_stream_zero_fault_ctrl;
    localparam int NB = 4;
    localparam int CW = 3;
`ifdef HWPE_STREAM_ZERO_FAULT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hwpe_stream_zero_fault_ctrl_if #(.NB_CHAN(NB), .CNT_WIDTH(CW)) bus ();

    hwpe_stream_zero_fault_ctrl #(.NB_CHAN(NB), .ARM_CYCLES(4), .CNT_WIDTH(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctrl   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] cnt(input int i);
        return 32'(bus.fault_cnt_o[i*CW +: CW]);
    endfunction

    function automatic logic [31:0] ecnt(input logic [31:0] v);
        return CNT_ON ? v : 32'd0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_status"}, 32'(bus.fault_status_o), 32'd0);
        chk({tag, "_first"},  32'(bus.first_idx_o),    32'd0);
        chk({tag, "_irq"},    32'(bus.fault_irq_o),    32'd0);
        chk({tag, "_armed"},  32'(bus.armed_o),        32'd0);
        chk({tag, "_cnt"},    32'(bus.fault_cnt_o),    32'd0);
    endtask

    initial begin
        bus.enable_i = 1'b0;
        bus.clear_i  = 1'b0;
        bus.mask_i   = '0;
        bus.fault_i  = '0;
        step(3);
        chk_all_zero("reset");

        // Arming window ignores faults; armed_o rises on the 5th edge
        rst_n = 1'b1;
        bus.enable_i = 1'b1;
        step(2);
        bus.fault_i = 4'b0010;
        step(1);
        bus.fault_i = 4'b0000;
        step(1);
        chk("arm_armed_lo", 32'(bus.armed_o), 32'd0);
        chk("arm_status",   32'(bus.fault_status_o), 32'd0);
        step(1);
        chk("arm_armed_hi", 32'(bus.armed_o), 32'd1);
        chk("arm_irq",      32'(bus.fault_irq_o), 32'd0);

        // First fault capture
        bus.fault_i = 4'b1100;
        step(1);
        bus.fault_i = 4'b0000;
        chk("ff_status", 32'(bus.fault_status_o), 32'hC);
        chk("ff_first",  32'(bus.first_idx_o), 32'd2);
        chk("ff_irq",    32'(bus.fault_irq_o), 32'd1);
        chk("ff_cnt2",   cnt(2), ecnt(1));
        chk("ff_cnt3",   cnt(3), ecnt(1));
        chk("ff_cnt0",   cnt(0), 32'd0);

        // Plain clear returns to MONITOR
        bus.clear_i = 1'b1;
        step(1);
        bus.clear_i = 1'b0;
        chk("clr_status", 32'(bus.fault_status_o), 32'd0);
        chk("clr_irq",    32'(bus.fault_irq_o), 32'd0);
        chk("clr_armed",  32'(bus.armed_o), 32'd1);
        chk("clr_cnt",    32'(bus.fault_cnt_o), 32'd0);

        // Masking
        bus.mask_i  = 4'b0001;
        bus.fault_i = 4'b0001;
        step(10);
        chk("msk_status", 32'(bus.fault_status_o), 32'd0);
        chk("msk_irq",    32'(bus.fault_irq_o), 32'd0);
        bus.fault_i = 4'b0011;
        step(1);
        bus.fault_i = 4'b0000;
        bus.mask_i  = 4'b0000;
        chk("msk2_status", 32'(bus.fault_status_o), 32'h2);
        chk("msk2_first",  32'(bus.first_idx_o), 32'd1);
        chk("msk2_irq",    32'(bus.fault_irq_o), 32'd1);
        chk("msk2_cnt0",   cnt(0), 32'd0);

        // Clear/fault collision: fault wins
        bus.clear_i = 1'b1;
        step(1);
        bus.clear_i = 1'b0;
        bus.fault_i = 4'b1000;
        step(1);
        chk("col_pre_status", 32'(bus.fault_status_o), 32'h8);
        chk("col_pre_first",  32'(bus.first_idx_o), 32'd3);
        bus.clear_i = 1'b1;
        bus.fault_i = 4'b0001;
        step(1);
        bus.clear_i = 1'b0;
        bus.fault_i = 4'b0000;
        chk("col_status", 32'(bus.fault_status_o), 32'h1);
        chk("col_first",  32'(bus.first_idx_o), 32'd0);
        chk("col_irq",    32'(bus.fault_irq_o), 32'd1);
        chk("col_cnt0",   cnt(0), ecnt(1));
        chk("col_cnt3",   cnt(3), 32'd0);

        // Saturation
        bus.clear_i = 1'b1;
        step(1);
        bus.clear_i = 1'b0;
        bus.fault_i = 4'b0010;
        step(12);
        bus.fault_i = 4'b0000;
        chk("sat_cnt1",   cnt(1), ecnt(7));
        chk("sat_cnt0",   cnt(0), 32'd0);
        chk("sat_status", 32'(bus.fault_status_o), 32'h2);

        // Disable in FAULT: status retained, irq/armed drop
        bus.enable_i = 1'b0;
        step(1);
        chk("dis_armed",  32'(bus.armed_o), 32'd0);
        chk("dis_irq",    32'(bus.fault_irq_o), 32'd0);
        chk("dis_status", 32'(bus.fault_status_o), 32'h2);
        chk("dis_first",  32'(bus.first_idx_o), 32'd1);
        chk("dis_cnt1",   cnt(1), ecnt(7));

        // Async reset mid-ARMING, then arming restarts
        bus.enable_i = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step(4);
        chk("rearm_lo", 32'(bus.armed_o), 32'd0);
        step(1);
        chk("rearm_hi", 32'(bus.armed_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
